color_blob_tracker: RTL and testbench

Avalon-ST video stage placed directly downstream of the camera streamer's 24-bit RGB source and upstream of the display/DMA sink. Forwards every pixel unchanged through a 2-entry skid buffer. Counts pixel coordinates and classifies each pixel against a programmable RGB window. Publishes the per-frame bounding box and match count of in-window pixels when the frame's end-of-packet is accepted.

---
 rtl/video_pkg.sv | 41 ++++
 rtl/stream_skid_buffer.sv | 69 ++++++
 rtl/color_blob_tracker.sv | 225 ++++++++++++++++++++++
 tb/tb_color_blob_tracker.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: default frame geometry, coordinate/count widths,
// the packed RGB888 pixel type and the per-channel window compare.
package video_pkg;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int COORD_W    = 10;
  localparam int COUNT_W    = 19;
  localparam int PIX_W      = 24;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } track_state_t;

  function automatic logic chan_in_window(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // An inverted channel window (lo > hi) can never be satisfied.
  function automatic logic rgb_in_window(input rgb888_t p,
                                         input rgb888_t lo,
                                         input rgb888_t hi);
    return chan_in_window(p.r, lo.r, hi.r) &&
           chan_in_window(p.g, lo.g, hi.g) &&
           chan_in_window(p.b, lo.b, hi.b);
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry Avalon-ST skid buffer carrying data with SOP/EOP; ready is a
// register so the sink never sees a combinational path from out_ready.
module stream_skid_buffer #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_startofpacket,
  input  logic          in_endofpacket,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_startofpacket,
  output logic          out_endofpacket,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int EW = DW + 2;

  logic [EW-1:0] head_q;
  logic [EW-1:0] tail_q;
  logic [EW-1:0] in_beat;
  logic [1:0]    count_q;
  logic [1:0]    count_next;
  logic          accept;
  logic          emit;

  assign in_beat   = {in_data, in_startofpacket, in_endofpacket};
  assign accept    = in_valid && in_ready;
  assign out_valid = (count_q != 2'd0);
  assign emit      = out_valid && out_ready;

  assign {out_data, out_startofpacket, out_endofpacket} = head_q;

  always_comb begin
    count_next = count_q;
    unique case ({accept, emit})
      2'b10:   count_next = count_q + 2'd1;
      2'b01:   count_next = count_q - 2'd1;
      default: count_next = count_q;
    endcase
  end

  // Head is always the oldest beat; tail only fills when head is stalled.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      count_q  <= 2'd0;
      in_ready <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      count_q  <= count_next;
      in_ready <= (count_next != 2'd2);
      if (emit && (count_q == 2'd2)) begin
        head_q <= tail_q;
      end
      if (accept) begin
        if ((count_q == 2'd0) || ((count_q == 2'd1) && emit)) begin
          head_q <= in_beat;
        end else begin
          tail_q <= in_beat;
        end
      end
    end
  end

endmodule

// File: rtl/color_blob_tracker.sv
// Pass-through video stage that measures the bounding box and pixel count of
// pixels inside a programmable RGB window, publishing results per frame.
module color_blob_tracker
  import video_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int DW     = PIX_W
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [DW-1:0]      in_data,
  input  logic               in_startofpacket,
  input  logic               in_endofpacket,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DW-1:0]      out_data,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic [23:0]        thr_min,
  input  logic [23:0]        thr_max,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [COUNT_W-1:0] match_count,
  output logic               found,
  output logic               result_valid,
  output logic               frame_error
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  stream_skid_buffer #(.DW(DW)) u_skid (
    .clk               (clk),
    .n_reset           (n_reset),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_valid         (out_valid),
    .out_ready         (out_ready)
  );

  track_state_t state_q, state_next;

  logic               accept;
  logic               start_frame;
  logic               count_pixel;
  logic               publish;
  logic               error_now;
  logic               set_overflow;
  logic               overflow_q;
  logic               at_last;
  logic               hit;

  logic [COORD_W-1:0] x_q, y_q, cur_x, cur_y;
  rgb888_t            pix, lo_q, hi_q, lo_eff, hi_eff;

  logic [COUNT_W-1:0] cnt_q, base_cnt, new_cnt;
  logic               any_q, base_any, new_any;
  logic [COORD_W-1:0] bx_lo_q, bx_hi_q, by_lo_q, by_hi_q;
  logic [COORD_W-1:0] base_x_lo, base_x_hi, base_y_lo, base_y_hi;
  logic [COORD_W-1:0] new_x_lo, new_x_hi, new_y_lo, new_y_hi;

  assign accept  = in_valid && in_ready;
  assign pix     = '{r: in_data[R_LSB +: 8], g: in_data[G_LSB +: 8], b: in_data[B_LSB +: 8]};
  assign cur_x   = in_startofpacket ? '0 : x_q;
  assign cur_y   = in_startofpacket ? '0 : y_q;
  assign at_last = (cur_x == X_LAST) && (cur_y == Y_LAST);
  assign lo_eff  = in_startofpacket ? rgb888_t'(thr_min) : lo_q;
  assign hi_eff  = in_startofpacket ? rgb888_t'(thr_max) : hi_q;
  assign hit     = count_pixel && rgb_in_window(pix, lo_eff, hi_eff);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // An SOP always restarts a frame, even one already in progress.
  always_comb begin
    state_next   = state_q;
    start_frame  = 1'b0;
    count_pixel  = 1'b0;
    publish      = 1'b0;
    error_now    = 1'b0;
    set_overflow = 1'b0;
    if (accept) begin
      if (in_startofpacket) begin
        start_frame = 1'b1;
        count_pixel = 1'b1;
        if (state_q == ST_ACTIVE) begin
          error_now = 1'b1;
        end
        if (in_endofpacket) begin
          publish    = 1'b1;
          state_next = ST_IDLE;
          if (!at_last) begin
            error_now = 1'b1;
          end
        end else begin
          state_next = ST_ACTIVE;
          if (at_last) begin
            error_now    = 1'b1;
            set_overflow = 1'b1;
          end
        end
      end else if (state_q == ST_ACTIVE) begin
        count_pixel = !overflow_q;
        if (in_endofpacket) begin
          publish    = 1'b1;
          state_next = ST_IDLE;
          if (!at_last || overflow_q) begin
            error_now = 1'b1;
          end
        end else if (at_last && !overflow_q) begin
          error_now    = 1'b1;
          set_overflow = 1'b1;
        end
      end
    end
  end

  // First hit seeds the whole box; later hits only widen it.
  always_comb begin
    base_cnt  = start_frame ? '0   : cnt_q;
    base_any  = start_frame ? 1'b0 : any_q;
    base_x_lo = start_frame ? '0   : bx_lo_q;
    base_x_hi = start_frame ? '0   : bx_hi_q;
    base_y_lo = start_frame ? '0   : by_lo_q;
    base_y_hi = start_frame ? '0   : by_hi_q;
    new_cnt   = base_cnt;
    new_any   = base_any;
    new_x_lo  = base_x_lo;
    new_x_hi  = base_x_hi;
    new_y_lo  = base_y_lo;
    new_y_hi  = base_y_hi;
    if (hit) begin
      if (base_cnt != '1) begin
        new_cnt = base_cnt + COUNT_W'(1);
      end
      new_any = 1'b1;
      if (!base_any) begin
        new_x_lo = cur_x;
        new_x_hi = cur_x;
        new_y_lo = cur_y;
        new_y_hi = cur_y;
      end else begin
        if (cur_x < base_x_lo) new_x_lo = cur_x;
        if (cur_x > base_x_hi) new_x_hi = cur_x;
        if (cur_y < base_y_lo) new_y_lo = cur_y;
        if (cur_y > base_y_hi) new_y_hi = cur_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      x_q          <= '0;
      y_q          <= '0;
      overflow_q   <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
      cnt_q        <= '0;
      any_q        <= 1'b0;
      bx_lo_q      <= '0;
      bx_hi_q      <= '0;
      by_lo_q      <= '0;
      by_hi_q      <= '0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      match_count  <= '0;
      found        <= 1'b0;
      result_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      result_valid <= publish;
      frame_error  <= error_now;
      if (start_frame) begin
        lo_q       <= rgb888_t'(thr_min);
        hi_q       <= rgb888_t'(thr_max);
        overflow_q <= 1'b0;
      end
      if (set_overflow) begin
        overflow_q <= 1'b1;
      end
      if (count_pixel) begin
        if (cur_x == X_LAST) begin
          x_q <= '0;
          y_q <= cur_y + COORD_W'(1);
        end else begin
          x_q <= cur_x + COORD_W'(1);
          y_q <= cur_y;
        end
        cnt_q   <= new_cnt;
        any_q   <= new_any;
        bx_lo_q <= new_x_lo;
        bx_hi_q <= new_x_hi;
        by_lo_q <= new_y_lo;
        by_hi_q <= new_y_hi;
      end
      if (publish) begin
        match_count <= new_cnt;
        found       <= new_any;
        x_min       <= new_any ? new_x_lo : '0;
        x_max       <= new_any ? new_x_hi : '0;
        y_min       <= new_any ? new_y_lo : '0;
        y_max       <= new_any ? new_y_hi : '0;
      end
    end
  end

endmodule

// File: tb/tb_color_blob_tracker.sv
// Randomized scoreboard bench for color_blob_tracker on a small 16x8 frame.
module tb_color_blob_tracker;
  import video_pkg::*;

  localparam int W = 16;
  localparam int H = 8;
  localparam int N = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               n_reset = 1'b0;
  logic [23:0]        in_data = '0;
  logic               in_startofpacket = 1'b0;
  logic               in_endofpacket = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [23:0]        out_data;
  logic               out_startofpacket;
  logic               out_endofpacket;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [23:0]        thr_min = '0;
  logic [23:0]        thr_max = '0;
  logic [COORD_W-1:0] x_min, x_max, y_min, y_max;
  logic [COUNT_W-1:0] match_count;
  logic               found;
  logic               result_valid;
  logic               frame_error;

  color_blob_tracker #(.WIDTH(W), .HEIGHT(H), .DW(24)) dut (
    .clk               (clk),
    .n_reset           (n_reset),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .thr_min           (thr_min),
    .thr_max           (thr_max),
    .x_min             (x_min),
    .x_max             (x_max),
    .y_min             (y_min),
    .y_max             (y_max),
    .match_count       (match_count),
    .found             (found),
    .result_valid      (result_valid),
    .frame_error       (frame_error)
  );

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [23:0] data;
  } beat_t;

  typedef struct {
    logic rv;
    logic fe;
    int   xmin, xmax, ymin, ymax, cnt;
    logic fnd;
  } event_t;

  beat_t  exp_pix[$];
  event_t exp_ev[$];
  int     tests = 0;
  int     fails = 0;

  int     ready_pct = 100;
  int     gap_pct = 0;
  bit     thr_jitter = 0;

  // Reference model: a frame is just the list of pixels since its SOP.
  bit          in_frame = 0;
  logic [23:0] frame_q[$];
  logic [23:0] lat_min, lat_max;
  int          pub_xmin = 0, pub_xmax = 0, pub_ymin = 0, pub_ymax = 0, pub_cnt = 0;
  logic        pub_fnd = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic bit in_window(input logic [23:0] p, input logic [23:0] lo, input logic [23:0] hi);
    bit ok = 1;
    for (int c = 0; c < 3; c++) begin
      int v = int'((p >> (8 * c)) & 24'hFF);
      int l = int'((lo >> (8 * c)) & 24'hFF);
      int h = int'((hi >> (8 * c)) & 24'hFF);
      if (v < l || v > h) ok = 0;
    end
    return ok;
  endfunction

  task automatic publish_model();
    int cnt = 0;
    int xl = 0, xh = 0, yl = 0, yh = 0;
    int lim = (frame_q.size() < N) ? frame_q.size() : N;
    for (int k = 0; k < lim; k++) begin
      int x = k % W;
      int y = k / W;
      if (in_window(frame_q[k], lat_min, lat_max)) begin
        if (cnt == 0) begin
          xl = x; xh = x; yl = y; yh = y;
        end else begin
          if (x < xl) xl = x;
          if (x > xh) xh = x;
          if (y < yl) yl = y;
          if (y > yh) yh = y;
        end
        cnt++;
      end
    end
    pub_cnt = cnt; pub_fnd = (cnt != 0);
    pub_xmin = xl; pub_xmax = xh; pub_ymin = yl; pub_ymax = yh;
  endtask

  task automatic model_accept(input logic [23:0] pix, input bit sop, input bit eop);
    event_t ev;
    ev.rv = 0;
    ev.fe = 0;
    exp_pix.push_back('{sop: sop, eop: eop, data: pix});
    if (sop) begin
      if (in_frame) ev.fe = 1;
      in_frame = 1;
      frame_q.delete();
      lat_min = thr_min;
      lat_max = thr_max;
    end
    if (in_frame) begin
      int n;
      frame_q.push_back(pix);
      n = frame_q.size() - 1;
      if (eop) begin
        ev.rv = 1;
        if (n != N - 1) ev.fe = 1;
        publish_model();
        in_frame = 0;
      end else if (n == N - 1) begin
        ev.fe = 1;
      end
    end
    if (ev.rv || ev.fe) begin
      ev.xmin = pub_xmin; ev.xmax = pub_xmax; ev.ymin = pub_ymin; ev.ymax = pub_ymax;
      ev.cnt = pub_cnt; ev.fnd = pub_fnd;
      exp_ev.push_back(ev);
    end
  endtask

  function automatic logic [7:0] pal_val();
    case ($urandom_range(0, 4))
      0: return 8'h10;
      1: return 8'h40;
      2: return 8'h80;
      3: return 8'hC0;
      default: return 8'hF0;
    endcase
  endfunction

  function automatic logic [23:0] gen_pixel(input int mode, input int x, input int y);
    if (mode == 0) return (x >= 3 && x <= 7 && y >= 2 && y <= 4) ? 24'hFF0000 : 24'h000000;
    if (mode == 1) return 24'h000000;
    return {pal_val(), pal_val(), pal_val()};
  endfunction

  // Called and returns on a falling edge; the beat is taken on the rising edge between.
  task automatic applyStimulus(input logic [23:0] pix, input bit sop, input bit eop);
    int waited = 0;
    while ($urandom_range(0, 99) < gap_pct) @(negedge clk);
    if (thr_jitter) begin
      thr_min = {8'($urandom_range(0, 8'h90)), 8'($urandom_range(0, 8'h90)), 8'($urandom_range(0, 8'h90))};
      thr_max = {8'($urandom_range(8'h60, 8'hFF)), 8'($urandom_range(8'h60, 8'hFF)), 8'($urandom_range(8'h60, 8'hFF))};
    end
    in_data = pix;
    in_startofpacket = sop;
    in_endofpacket = eop;
    in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 1000) begin
        checkOutput("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    model_accept(pix, sop, eop);
    @(negedge clk);
    in_valid = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
  endtask

  task automatic send_frame(input int npix, input int mode, input bit with_eop);
    for (int k = 0; k < npix; k++) begin
      applyStimulus(gen_pixel(mode, k % W, k / W), k == 0, with_eop && (k == npix - 1));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_pix.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_done", 32'(exp_pix.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
    checkOutput({tag, "_out_sop_eop"}, 32'({out_startofpacket, out_endofpacket}), 32'd0);
    checkOutput({tag, "_box"}, 32'(x_min | x_max | y_min | y_max), 32'd0);
    checkOutput({tag, "_count"}, 32'(match_count), 32'd0);
    checkOutput({tag, "_flags"}, 32'({found, result_valid, frame_error}), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    n_reset = 1'b0;
    in_valid = 1'b0;
    exp_pix.delete();
    in_frame = 0;
    frame_q.delete();
    pub_xmin = 0; pub_xmax = 0; pub_ymin = 0; pub_ymax = 0; pub_cnt = 0; pub_fnd = 0;
    @(negedge clk);
    check_all_zero(tag);
    n_reset = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_ready_rise"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: checks every emitted beat and every result/error pulse against the queues.
  initial begin
    int     occ = 0;
    beat_t  b;
    event_t ev;
    forever begin
      @(negedge clk);
      #1;
      if (!n_reset) begin
        occ = 0;
        continue;
      end
      if (occ == 2) checkOutput("in_ready_when_full", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_pix.size() == 0) begin
          checkOutput("unexpected_pixel", 32'(out_data), 32'hFFFFFFFF);
        end else begin
          b = exp_pix.pop_front();
          checkOutput("pix_data", 32'(out_data), 32'(b.data));
          checkOutput("pix_sop_eop", 32'({out_startofpacket, out_endofpacket}), 32'({b.sop, b.eop}));
        end
      end
      if (result_valid || frame_error) begin
        if (exp_ev.size() == 0) begin
          checkOutput("unexpected_result", 32'({result_valid, frame_error}), 32'd0);
        end else begin
          ev = exp_ev.pop_front();
          checkOutput("result_valid", 32'(result_valid), 32'(ev.rv));
          checkOutput("frame_error", 32'(frame_error), 32'(ev.fe));
          checkOutput("x_min", 32'(x_min), 32'(ev.xmin));
          checkOutput("x_max", 32'(x_max), 32'(ev.xmax));
          checkOutput("y_min", 32'(y_min), 32'(ev.ymin));
          checkOutput("y_max", 32'(y_max), 32'(ev.ymax));
          checkOutput("match_count", 32'(match_count), 32'(ev.cnt));
          checkOutput("found", 32'(found), 32'(ev.fnd));
        end
      end
      occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    n_reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready_rise", 32'(in_ready), 32'd1);

    thr_min = 24'hC00000;
    thr_max = 24'hFF3F3F;
    ready_pct = 100;
    gap_pct = 0;
    send_frame(N, 0, 1);
    drain();
    checkOutput("block_x_min", 32'(x_min), 32'd3);
    checkOutput("block_x_max", 32'(x_max), 32'd7);
    checkOutput("block_y_min", 32'(y_min), 32'd2);
    checkOutput("block_y_max", 32'(y_max), 32'd4);
    checkOutput("block_count", 32'(match_count), 32'd15);
    checkOutput("block_found", 32'(found), 32'd1);

    ready_pct = 30;
    gap_pct = 20;
    send_frame(N, 0, 1);
    drain();
    checkOutput("block_bp_count", 32'(match_count), 32'd15);

    send_frame(N, 1, 1);
    drain();
    checkOutput("nomatch_found", 32'(found), 32'd0);
    checkOutput("nomatch_box", 32'(x_min | x_max | y_min | y_max), 32'd0);

    send_frame(50, 0, 1);
    send_frame(40, 0, 0);
    send_frame(N, 0, 1);
    drain();

    for (int k = 0; k < 5; k++) applyStimulus(24'hFF0000, 0, 0);
    send_frame(30, 0, 0);
    drain();
    do_reset("mid_reset");
    for (int k = 0; k < 5; k++) applyStimulus(24'hFF0000, 0, k == 4);
    send_frame(N, 0, 1);
    drain();

    applyStimulus(24'hFF0000, 1, 1);
    send_frame(N + 6, 2, 1);
    drain();

    thr_jitter = 1;
    ready_pct = 60;
    for (int f = 0; f < 6; f++) begin
      send_frame(N, 2, 1);
    end
    thr_jitter = 0;
    drain();

    checkOutput("hold_count", 32'(match_count), 32'(pub_cnt));
    checkOutput("hold_x_min", 32'(x_min), 32'(pub_xmin));
    checkOutput("hold_y_max", 32'(y_max), 32'(pub_ymax));
    checkOutput("events_consumed", 32'(exp_ev.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
